// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer.
//  - Opcode encodings seen on the 3-bit OP_Code field of an instruction.
//  - FSM state encoding used by alu_issue_ctrl.
//  - Bit positions of the N, Z, C, V flags inside a 4-bit NZCV vector.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPT
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the decode stage / external ALU and alu_issue_ctrl.
//  instr_valid/instr_ready/instr : instruction handshake, instr = {op[6:4], rd[3:2], rs[1:0]}
//  ld_en/ld_addr/ld_data         : direct register load strobe
//  rd_addr/rd_data               : combinational register readback
//  alu_a/alu_b/alu_op            : registered operands and opcode to the ALU
//  alu_result/alu_nzcv           : combinational ALU outputs
//  flags                         : architectural NZCV register
//  done/illegal                  : one-cycle completion / rejection pulses
// Modport slave is the sequencer; master is the decode stage plus the ALU.
interface alu_issue_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int DW       = 8
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic              instr_valid;
  logic              instr_ready;
  logic [6:0]        instr;
  logic              ld_en;
  logic [REG_AW-1:0] ld_addr;
  logic [DW-1:0]     ld_data;
  logic [REG_AW-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [2:0]        alu_op;
  logic [DW-1:0]     alu_result;
  logic [3:0]        alu_nzcv;
  logic [3:0]        flags;
  logic              done;
  logic              illegal;

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr, alu_result, alu_nzcv,
    input  instr_ready, rd_data, alu_a, alu_b, alu_op, flags, done, illegal
  );

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr, alu_result, alu_nzcv,
    output instr_ready, rd_data, alu_a, alu_b, alu_op, flags, done, illegal
  );

endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x DW register file with asynchronous active-low reset.
//  clk, rst_n          : clock and reset
//  ld_en/ld_addr/ld_data : load source for the write port
//  wb_en/wb_addr/wb_data : writeback source for the write port (wins on the same register)
//  ra_*, rb_*, rc_*      : three combinational read ports (operand A, operand B, readback)
module alu_regfile #(
  parameter int NUM_REGS = 4,
  parameter int DW       = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DW-1:0]     ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  input  logic [REG_AW-1:0] rc_addr,
  output logic [DW-1:0]     rc_data
);

  logic [DW-1:0] regs_q [NUM_REGS];

  // Write port muxed per register: the ALU writeback overrides a load
  // aimed at the same register, while a load to any other register
  // still lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_addr == REG_AW'(i))) regs_q[i] <= wb_data;
        else if (ld_en && (ld_addr == REG_AW'(i))) regs_q[i] <= ld_data;
      end
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rc_data = regs_q[rc_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the external combinational ALU.
// Accepts one register-to-register instruction, issues R[rd]/R[rs] to the
// ALU, captures Result/NZCV, then writes R[rd] and the Flags register.
//  clk   : clock, rising edge
//  rst_n : asynchronous reset, active low
//  bus   : alu_issue_ctrl_if.slave (handshake, load, readback, ALU, status)
// Optional feature: define ALU_CMP_EN to make opcode 101 a CMP (SUB that
// only updates Flags); otherwise 101 is rejected like 110/111.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DW       = 8
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam int REG_AW = $clog2(NUM_REGS);

  state_t            state_q, state_d;
  logic              ready_en_q;
  logic              instr_ready;
  logic              accept;
  logic              illegal_req;
  logic [2:0]        op_in;
  logic [REG_AW-1:0] rd_in, rs_in;
  logic              op_is_cmp;
  logic              op_legal;
  logic [REG_AW-1:0] rd_q;
  logic              cmp_q;
  logic [DW-1:0]     res_q;
  logic [3:0]        nzcv_q;
  logic [DW-1:0]     rf_a, rf_b;
  logic              wb_en;

  assign op_in = bus.instr[6:4];
  assign rd_in = REG_AW'(bus.instr[3:2]);
  assign rs_in = REG_AW'(bus.instr[1:0]);

`ifdef ALU_CMP_EN
  assign op_is_cmp = (op_in == OP_CMP);
`else
  assign op_is_cmp = 1'b0;
`endif
  assign op_legal = (op_in <= OP_XOR) || op_is_cmp;

  // CMP never writes the register file; every other instruction writes Rd.
  assign wb_en = (state_q == ST_CAPT) && !cmp_q;

  alu_regfile #(.NUM_REGS(NUM_REGS), .DW(DW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (bus.ld_en),
    .ld_addr (bus.ld_addr),
    .ld_data (bus.ld_data),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (res_q),
    .ra_addr (rd_in),
    .ra_data (rf_a),
    .rb_addr (rs_in),
    .rb_data (rf_b),
    .rc_addr (bus.rd_addr),
    .rc_data (bus.rd_data)
  );

  // State register. ready_en_q keeps instr_ready low while in reset and
  // releases it on the first clock edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next state and handshake decode. A load in IDLE steals the cycle, and an
  // illegal opcode is consumed without leaving IDLE.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    illegal_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = ready_en_q && !bus.ld_en;
        if (bus.instr_valid && instr_ready) begin
          if (op_legal) begin
            accept  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            illegal_req = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.instr_ready = instr_ready;

  // Datapath: operands are frozen at accept so later loads cannot disturb
  // the in-flight ALU inputs; the ALU output is captured at the end of
  // ISSUE and committed to Flags (and Rd via the regfile) at the end of CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_op  <= OP_ADD;
      bus.flags   <= '0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      rd_q        <= '0;
      cmp_q       <= 1'b0;
      res_q       <= '0;
      nzcv_q      <= '0;
    end else begin
      bus.done    <= (state_q == ST_CAPT);
      bus.illegal <= illegal_req;
      if (accept) begin
        bus.alu_a  <= rf_a;
        bus.alu_b  <= rf_b;
        bus.alu_op <= op_is_cmp ? OP_SUB : op_in;
        rd_q       <= rd_in;
        cmp_q      <= op_is_cmp;
      end
      if (state_q == ST_ISSUE) begin
        res_q  <= bus.alu_result;
        nzcv_q <= bus.alu_nzcv;
      end
      if (state_q == ST_CAPT) bus.flags <= nzcv_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 8-bit ALU and an
// arithmetic reference model of the register file and Flags.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

`ifdef ALU_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_regs [4];
  int   m_flags = 0;

  alu_issue_ctrl_if #(.NUM_REGS(4), .DW(8)) bus ();

  alu_issue_ctrl #(.NUM_REGS(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driven by the registered operands.
  logic [8:0] alu_wide;
  logic [7:0] alu_res;
  logic       alu_c, alu_v;
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res  = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (bus.alu_a[7] == bus.alu_b[7]) && (alu_res[7] != bus.alu_a[7]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        alu_res  = alu_wide[7:0];
        alu_c    = ~alu_wide[8];
        alu_v    = (bus.alu_a[7] != bus.alu_b[7]) && (alu_res[7] != bus.alu_a[7]);
      end
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      OP_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_nzcv   = {alu_res[7], (alu_res == 8'h00), alu_c, alu_v};

  // Reference model: executes one instruction on m_regs/m_flags, returns 0 if illegal.
  function automatic bit model_exec(input int op, input int rd, input int rs);
    int a, b, sa, sb, full, sres, res;
    bit c, v;
    if (!(op <= 4 || (op == 5 && CMP_EN))) return 1'b0;
    a = m_regs[rd];
    b = m_regs[rs];
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin full = a + b; res = full % 256; c = (full > 255); sres = sa + sb; v = (sres > 127) || (sres < -128); end
      1, 5: begin full = a - b; res = (full + 256) % 256; c = (a >= b); sres = sa - sb; v = (sres > 127) || (sres < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      default: res = 0;
    endcase
    m_flags = (int'(res >= 128) << FLAG_N) | (int'(res == 0) << FLAG_Z) |
              (int'(c) << FLAG_C) | (int'(v) << FLAG_V);
    if (op != 5) m_regs[rd] = res;
    return 1'b1;
  endfunction

  task automatic do_load(input int addr, input int data);
    @(negedge clk);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 2'(addr);
    bus.ld_data = 8'(data);
    @(negedge clk);
    bus.ld_en = 1'b0;
    m_regs[addr] = data;
  endtask

  task automatic read_reg(input int addr, output logic [7:0] d);
    bus.rd_addr = 2'(addr);
    #1;
    d = bus.rd_data;
  endtask

  // Presents one instruction in IDLE and watches five cycles after the accept edge.
  task automatic send_instr(input int op, input int rd, input int rs,
                            output int done_cyc, output logic ill_seen, output logic rdy1,
                            output logic [7:0] a_s, output logic [7:0] b_s, output logic [2:0] op_s);
    done_cyc = -1;
    ill_seen = 1'b0;
    rdy1 = 1'b0;
    a_s = '0;
    b_s = '0;
    op_s = '0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {3'(op), 2'(rd), 2'(rs)};
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      if (c == 1) begin
        a_s = bus.alu_a; b_s = bus.alu_b; op_s = bus.alu_op; rdy1 = bus.instr_ready;
      end
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (bus.illegal) ill_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [27:0] obs;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.instr_ready, bus.done, bus.illegal, bus.flags, bus.alu_op, bus.alu_a, bus.alu_b};
    n_tests++;
    if (obs !== 28'h0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected 0", obs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.instr_ready); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_r%0d: got %h expected 00", i, d); end
    end
  endtask

  task automatic test_add();
    int dc; logic il, r1; logic [7:0] a, b, d; logic [2:0] o;
    do_load(0, 'hE4);
    do_load(1, 'hA2);
    send_instr(0, 0, 1, dc, il, r1, a, b, o);
    void'(model_exec(0, 0, 1));
    n_tests++;
    if (dc !== 3) begin n_fail++; $display("[TB] FAIL add_done_cycle: got %0d expected 3", dc); end
    read_reg(0, d);
    n_tests++;
    if (d !== 8'h86) begin n_fail++; $display("[TB] FAIL add_r0: got %h expected 86", d); end
    n_tests++;
    if (bus.flags !== 4'b1010) begin n_fail++; $display("[TB] FAIL add_flags: got %b expected 1010", bus.flags); end
    n_tests++;
    if ({a, b} !== 16'hE4A2) begin n_fail++; $display("[TB] FAIL add_operands: got %h expected e4a2", {a, b}); end
  endtask

  task automatic test_logic();
    int dc; logic il, r1; logic [7:0] a, b, d; logic [2:0] o;
    do_load(2, 'hFF);
    do_load(3, 'h00);
    send_instr(2, 2, 3, dc, il, r1, a, b, o);
    void'(model_exec(2, 2, 3));
    read_reg(2, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("[TB] FAIL and_r2: got %h expected 00", d); end
    n_tests++;
    if (bus.flags[FLAG_Z] !== 1'b1) begin n_fail++; $display("[TB] FAIL and_z: got %b expected 1", bus.flags[FLAG_Z]); end
    send_instr(3, 3, 2, dc, il, r1, a, b, o);
    void'(model_exec(3, 3, 2));
    read_reg(3, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("[TB] FAIL or_r3: got %h expected 00", d); end
    n_tests++;
    if (bus.flags !== 4'(m_flags)) begin n_fail++; $display("[TB] FAIL or_flags: got %b expected %b", bus.flags, 4'(m_flags)); end
  endtask

  task automatic test_illegal();
    int dc; logic il, r1; logic [7:0] a, b, d; logic [2:0] o; logic [3:0] f0;
    do_load(0, 'h55);
    f0 = bus.flags;
    send_instr(6, 0, 1, dc, il, r1, a, b, o);
    n_tests++;
    if (il !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_pulse: got %b expected 1", il); end
    n_tests++;
    if (dc !== -1) begin n_fail++; $display("[TB] FAIL illegal_no_done: got %0d expected -1", dc); end
    n_tests++;
    if (r1 !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_ready: got %b expected 1", r1); end
    read_reg(0, d);
    n_tests++;
    if (d !== 8'h55) begin n_fail++; $display("[TB] FAIL illegal_r0: got %h expected 55", d); end
    n_tests++;
    if (bus.flags !== f0) begin n_fail++; $display("[TB] FAIL illegal_flags: got %b expected %b", bus.flags, f0); end
  endtask

  task automatic test_load_priority();
    int dc; logic [7:0] d;
    dc = -1;
    @(negedge clk);
    bus.ld_en = 1'b1; bus.ld_addr = 2'd3; bus.ld_data = 8'h5A;
    bus.instr_valid = 1'b1; bus.instr = {OP_ADD, 2'd3, 2'd3};
    #1;
    n_tests++;
    if (bus.instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ldprio_ready_low: got %b expected 0", bus.instr_ready); end
    @(negedge clk);
    bus.ld_en = 1'b0;
    m_regs[3] = 'h5A;
    #1;
    n_tests++;
    if (bus.instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ldprio_ready_high: got %b expected 1", bus.instr_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      if (bus.done && dc < 0) dc = c;
    end
    void'(model_exec(0, 3, 3));
    n_tests++;
    if (dc !== 3) begin n_fail++; $display("[TB] FAIL ldprio_done: got %0d expected 3", dc); end
    read_reg(3, d);
    n_tests++;
    if (d !== 8'(m_regs[3])) begin n_fail++; $display("[TB] FAIL ldprio_r3: got %h expected %h", d, 8'(m_regs[3])); end
    n_tests++;
    if (bus.flags !== 4'(m_flags)) begin n_fail++; $display("[TB] FAIL ldprio_flags: got %b expected %b", bus.flags, 4'(m_flags)); end
  endtask

  task automatic test_load_in_flight();
    logic [7:0] d, a2;
    a2 = '0;
    do_load(0, 'h11);
    do_load(1, 'h22);
    void'(model_exec(0, 0, 1));
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = {OP_ADD, 2'd0, 2'd1};
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 8'h99;
    @(negedge clk);
    a2 = bus.alu_a;
    bus.ld_addr = 2'd2; bus.ld_data = 8'h77;
    m_regs[2] = 'h77;
    @(negedge clk);
    bus.ld_en = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL inflight_done: got %b expected 1", bus.done); end
    n_tests++;
    if (a2 !== 8'h11) begin n_fail++; $display("[TB] FAIL inflight_operand: got %h expected 11", a2); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== 8'(m_regs[i])) begin n_fail++; $display("[TB] FAIL inflight_r%0d: got %h expected %h", i, d, 8'(m_regs[i])); end
    end
  endtask

  task automatic test_back_to_back();
    int first, second; logic rdy_bad; logic [7:0] d;
    first = -1; second = -1; rdy_bad = 1'b0;
    do_load(1, 'h40);
    do_load(2, 'h45);
    void'(model_exec(0, 1, 2));
    void'(model_exec(4, 0, 1));
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = {OP_ADD, 2'd1, 2'd2};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.instr = {OP_XOR, 2'd0, 2'd1};
      if (c == 4) bus.instr_valid = 1'b0;
      if (c <= 2 && bus.instr_ready !== 1'b0) rdy_bad = 1'b1;
      if (bus.done) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    n_tests++;
    if (rdy_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_ready: got %b expected 0", rdy_bad); end
    n_tests++;
    if (first !== 3 || second !== 6) begin n_fail++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 3,6", first, second); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== 8'(m_regs[i])) begin n_fail++; $display("[TB] FAIL b2b_r%0d: got %h expected %h", i, d, 8'(m_regs[i])); end
    end
    n_tests++;
    if (bus.flags !== 4'(m_flags)) begin n_fail++; $display("[TB] FAIL b2b_flags: got %b expected %b", bus.flags, 4'(m_flags)); end
  endtask

  task automatic test_reset_mid();
    logic [27:0] obs; logic [7:0] d; logic done_bad;
    done_bad = 1'b0;
    do_load(0, 'h3C);
    do_load(1, 'h0F);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = {OP_XOR, 2'd0, 2'd1};
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    obs = {bus.instr_ready, bus.done, bus.illegal, bus.flags, bus.alu_op, bus.alu_a, bus.alu_b};
    n_tests++;
    if (obs !== 28'h0) begin n_fail++; $display("[TB] FAIL rstmid_outputs: got %h expected 0", obs); end
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_flags = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_bad = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready: got %b expected 1", bus.instr_ready); end
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_bad = 1'b1;
    end
    n_tests++;
    if (done_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_no_done: got %b expected 0", done_bad); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("[TB] FAIL rstmid_r%0d: got %h expected 00", i, d); end
    end
  endtask

  task automatic test_cmp();
    int dc; logic il, r1, legal; logic [7:0] a, b, d; logic [2:0] o;
    do_load(0, 'h10);
    do_load(1, 'h10);
    send_instr(5, 0, 1, dc, il, r1, a, b, o);
    legal = model_exec(5, 0, 1);
    n_tests++;
    if (il !== !legal) begin n_fail++; $display("[TB] FAIL cmp_illegal: got %b expected %b", il, !legal); end
    n_tests++;
    if (dc !== (legal ? 3 : -1)) begin n_fail++; $display("[TB] FAIL cmp_done: got %0d expected %0d", dc, legal ? 3 : -1); end
    if (legal) begin
      n_tests++;
      if (o !== OP_SUB) begin n_fail++; $display("[TB] FAIL cmp_aluop: got %b expected 001", o); end
    end
    read_reg(0, d);
    n_tests++;
    if (d !== 8'h10) begin n_fail++; $display("[TB] FAIL cmp_r0: got %h expected 10", d); end
    n_tests++;
    if (bus.flags !== 4'(m_flags)) begin n_fail++; $display("[TB] FAIL cmp_flags: got %b expected %b", bus.flags, 4'(m_flags)); end
  endtask

  task automatic test_random();
    int dc, op, rd, rs, ea, eb; logic il, r1, legal; logic [7:0] a, b, d; logic [2:0] o;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, 3), $urandom_range(0, 255));
      op = $urandom_range(0, 7);
      rd = $urandom_range(0, 3);
      rs = $urandom_range(0, 3);
      ea = m_regs[rd];
      eb = m_regs[rs];
      send_instr(op, rd, rs, dc, il, r1, a, b, o);
      legal = model_exec(op, rd, rs);
      n_tests++;
      if (dc !== (legal ? 3 : -1) || il !== !legal) begin
        n_fail++;
        $display("[TB] FAIL rand_status it%0d op%0d: got done=%0d ill=%b expected done=%0d ill=%b", it, op, dc, il, legal ? 3 : -1, !legal);
      end
      if (legal) begin
        n_tests++;
        if ({o, a, b} !== {(op == 5) ? OP_SUB : 3'(op), 8'(ea), 8'(eb)}) begin
          n_fail++;
          $display("[TB] FAIL rand_issue it%0d: got %h expected %h", it, {o, a, b}, {(op == 5) ? OP_SUB : 3'(op), 8'(ea), 8'(eb)});
        end
      end
      n_tests++;
      if (bus.flags !== 4'(m_flags)) begin n_fail++; $display("[TB] FAIL rand_flags it%0d: got %b expected %b", it, bus.flags, 4'(m_flags)); end
      for (int i = 0; i < 4; i++) begin
        read_reg(i, d);
        n_tests++;
        if (d !== 8'(m_regs[i])) begin n_fail++; $display("[TB] FAIL rand_r%0d it%0d: got %h expected %h", i, it, d, 8'(m_regs[i])); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.rd_addr     = '0;
    test_reset();
    test_add();
    test_logic();
    test_illegal();
    test_load_priority();
    test_load_in_flight();
    test_back_to_back();
    test_cmp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
